// File: rtl/dmem_wait.sv
// Multi-cycle data memory with req/ready handshake, fixed access latency,
// word/byte accesses and fault reporting for misaligned or out-of-range addresses.
module dmem_wait #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        size,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic        ready,
  output logic        done,
  output logic [31:0] rd,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          we_reg;
  logic          size_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wd_reg;
  logic          ready_reg;
  logic          done_reg;
  logic [31:0]   rd_reg;
  logic          err_reg;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   mem_rd_reg;

  logic          accept;
  logic          complete;
  logic          fault;
  logic          mem_we;
  logic [AW-1:0] idx_in;
  logic [AW-1:0] idx_reg;
  logic [31:0]   merged_word;
  logic [7:0]    load_byte;
  logic [31:0]   load_word;
  logic [31:0]   result_word;

  assign accept   = req && ready_reg;
  assign complete = (state_reg == S_WAIT) && (cnt_reg == '0);
  assign fault    = ({2'b00, addr_reg[31:2]} >= 32'(DEPTH)) ||
                    (!size_reg && (addr_reg[1:0] != 2'b00));
  // Reset on the completion edge must suppress the write.
  assign mem_we   = complete && we_reg && !fault && !reset;
  assign idx_in   = addr[AW+1:2];
  assign idx_reg  = addr_reg[AW+1:2];

  // The target word is read at the accept edge; nothing else can write it
  // before completion, so it serves as the old value for byte merges.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_word[8*gi +: 8] =
        !size_reg                     ? wd_reg[8*gi +: 8] :
        (addr_reg[1:0] == 2'(gi))     ? wd_reg[7:0]       :
                                        mem_rd_reg[8*gi +: 8];
  end

  assign load_byte   = mem_rd_reg[{addr_reg[1:0], 3'b000} +: 8];
  assign load_word   = size_reg ? {24'b0, load_byte} : mem_rd_reg;
  assign result_word = fault ? 32'b0 : (we_reg ? merged_word : load_word);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_reg] <= merged_word;
    end
    if (accept) begin
      mem_rd_reg <= mem[idx_in];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      size_reg  <= 1'b0;
      addr_reg  <= '0;
      wd_reg    <= '0;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
      rd_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          done_reg <= 1'b0;
          if (req) begin
            we_reg    <= we;
            size_reg  <= size;
            addr_reg  <= addr;
            wd_reg    <= wd;
            cnt_reg   <= CW'(LATENCY - 1);
            state_reg <= S_WAIT;
            ready_reg <= 1'b0;
          end else begin
            state_reg <= S_IDLE;
            ready_reg <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= S_DONE;
            ready_reg <= 1'b1;
            done_reg  <= 1'b1;
            rd_reg    <= result_word;
            err_reg   <= fault;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b1;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_reg;
  assign done  = done_reg;
  assign rd    = rd_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait: one instance each at LATENCY 1, 2 and 16,
// table-driven single accesses plus back-to-back and mid-access reset sequences.
module tb_dmem_wait;

  localparam int DEPTH = 64;
  localparam int NDUT  = 3;
  localparam int NVEC  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_v [NDUT];
  logic        req_v   [NDUT];
  logic        we_v    [NDUT];
  logic        size_v  [NDUT];
  logic [31:0] addr_v  [NDUT];
  logic [31:0] wd_v    [NDUT];
  logic        ready_v [NDUT];
  logic        done_v  [NDUT];
  logic [31:0] rd_v    [NDUT];
  logic        err_v   [NDUT];

  int checks = 0;
  int errors = 0;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    dmem_wait #(
      .DEPTH  (DEPTH),
      .LATENCY((gi == 0) ? 1 : ((gi == 1) ? 2 : 16))
    ) u_dut (
      .clk  (clk),
      .reset(reset_v[gi]),
      .req  (req_v[gi]),
      .we   (we_v[gi]),
      .size (size_v[gi]),
      .addr (addr_v[gi]),
      .wd   (wd_v[gi]),
      .ready(ready_v[gi]),
      .done (done_v[gi]),
      .rd   (rd_v[gi]),
      .err  (err_v[gi])
    );
  end

  typedef struct {
    logic        w;
    logic        s;
    logic [31:0] a;
    logic [31:0] dat;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 16);
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lat=%0d actual=%h required=%h", nm, lat_of(d), act, exp);
    end
  endtask

  // One isolated access: checks completion latency, rd, err and pulse width.
  task automatic access(input int d, input string nm, input logic w, input logic s,
                        input logic [31:0] a, input logic [31:0] dat,
                        input logic [31:0] exp_rd, input logic exp_err);
    int j;
    @(negedge clk);
    chk({nm, "_ready_idle"}, d, 32'(ready_v[d]), 32'd1);
    req_v[d] = 1'b1; we_v[d] = w; size_v[d] = s; addr_v[d] = a; wd_v[d] = dat;
    @(negedge clk);
    req_v[d] = 1'b0; we_v[d] = ~w; size_v[d] = ~s; addr_v[d] = ~a; wd_v[d] = ~dat;
    j = 0;
    while (done_v[d] !== 1'b1 && j < 40) begin
      @(negedge clk);
      j++;
    end
    chk({nm, "_latency"}, d, 32'(j), 32'(lat_of(d)));
    chk({nm, "_rd"}, d, rd_v[d], exp_rd);
    chk({nm, "_err"}, d, 32'(err_v[d]), 32'(exp_err));
    $display("txn lat=%0d %s we=%0b size=%0b addr=%h wd=%h rd=%h err=%0b",
             lat_of(d), nm, w, s, a, dat, rd_v[d], err_v[d]);
    @(negedge clk);
    chk({nm, "_done_pulse"}, d, 32'(done_v[d]), 32'd0);
  endtask

  // req held high: store/load/store/load to @12, completions LATENCY+1 apart.
  task automatic b2b(input int d);
    logic [31:0] dat_a;
    logic [31:0] dat_b;
    logic [31:0] exp;
    int cyc;
    int last;
    int nd;
    int extra;
    dat_a = 32'hC0DE_0000 | 32'(d);
    dat_b = 32'h5EED_1000 | 32'(d);
    @(negedge clk);
    req_v[d] = 1'b1; we_v[d] = 1'b1; size_v[d] = 1'b0; addr_v[d] = 32'd12; wd_v[d] = dat_a;
    cyc = 0; last = 1; nd = 0;
    while (nd < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done_v[d] === 1'b1) begin
        exp = (nd < 2) ? dat_a : dat_b;
        chk($sformatf("b2b%0d_rd", nd), d, rd_v[d], exp);
        chk($sformatf("b2b%0d_err", nd), d, 32'(err_v[d]), 32'd0);
        chk($sformatf("b2b%0d_period", nd), d, 32'(cyc - last),
            32'((nd == 0) ? lat_of(d) : lat_of(d) + 1));
        $display("txn lat=%0d b2b%0d we=%0b rd=%h at_cycle=%0d", lat_of(d), nd, we_v[d], rd_v[d], cyc);
        last = cyc;
        nd++;
        if (nd == 1 || nd == 3) begin
          we_v[d] = 1'b0; wd_v[d] = 32'hFFFF_FFFF;
        end else if (nd == 2) begin
          we_v[d] = 1'b1; wd_v[d] = dat_b;
        end else begin
          req_v[d] = 1'b0;
        end
      end
    end
    chk("b2b_count", d, 32'(nd), 32'd4);
    req_v[d] = 1'b0;
    extra = 0;
    repeat (2 * lat_of(d) + 4) begin
      @(negedge clk);
      if (done_v[d] === 1'b1) extra++;
    end
    chk("b2b_no_extra_done", d, 32'(extra), 32'd0);
  endtask

  // Reset asserted one cycle after accepting a store: store must be lost.
  task automatic rst_mid(input int d);
    int nd;
    access(d, "pre_rst_st", 1'b1, 1'b0, 32'd20, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    req_v[d] = 1'b1; we_v[d] = 1'b1; size_v[d] = 1'b0; addr_v[d] = 32'd20; wd_v[d] = 32'hDEAD_BEEF;
    @(negedge clk);
    reset_v[d] = 1'b1;
    #1;
    chk("rst_ready", d, 32'(ready_v[d]), 32'd1);
    chk("rst_done", d, 32'(done_v[d]), 32'd0);
    chk("rst_rd", d, rd_v[d], 32'd0);
    chk("rst_err", d, 32'(err_v[d]), 32'd0);
    nd = 0;
    repeat (2) begin
      @(negedge clk);
      if (done_v[d] === 1'b1) nd++;
    end
    reset_v[d] = 1'b0;
    req_v[d] = 1'b0;
    repeat (lat_of(d) + 3) begin
      @(negedge clk);
      if (done_v[d] === 1'b1) nd++;
    end
    chk("rst_no_done", d, 32'(nd), 32'd0);
    access(d, "post_rst_ld", 1'b0, 1'b0, 32'd20, 32'd0, 32'h0BAD_F00D, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    //           w     s     addr    wd            exp_rd        exp_err
    vecs[0]  = '{1'b1, 1'b0, 32'd100, 32'h0000_0007, 32'h0000_0007, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'd100, 32'h0,         32'h0000_0007, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'd8,   32'h1122_3344, 32'h1122_3344, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'd9,   32'hFFFF_FFAB, 32'h1122_AB44, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'd9,   32'h0,         32'h0000_00AB, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'd8,   32'h0,         32'h1122_AB44, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'd11,  32'h1234_56CD, 32'hCD22_AB44, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'd10,  32'h0,         32'h0000_0022, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'd252, 32'h55AA_1234, 32'h55AA_1234, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'd6,   32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'd256, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'd254, 32'h0,         32'h0,         1'b1};
    vecs[12] = '{1'b1, 1'b1, 32'd259, 32'h0000_0077, 32'h0,         1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'd252, 32'h0,         32'h55AA_1234, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'd255, 32'h0,         32'h0000_0055, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 32'd8,   32'h0,         32'hCD22_AB44, 1'b0};

    for (int d = 0; d < NDUT; d++) begin
      reset_v[d] = 1'b1; req_v[d] = 1'b0; we_v[d] = 1'b0; size_v[d] = 1'b0;
      addr_v[d] = 32'd0; wd_v[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("init_ready", d, 32'(ready_v[d]), 32'd1);
      chk("init_done", d, 32'(done_v[d]), 32'd0);
      chk("init_rd", d, rd_v[d], 32'd0);
      chk("init_err", d, 32'(err_v[d]), 32'd0);
      reset_v[d] = 1'b0;
    end

    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < NVEC; i++) begin
        access(d, $sformatf("vec%0d", i), vecs[i].w, vecs[i].s, vecs[i].a,
               vecs[i].dat, vecs[i].exp_rd, vecs[i].exp_err);
      end
      b2b(d);
      rst_mid(d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_wait.md
# dmem_wait

Parametrised multi-cycle data memory for the multicycle ARM core. It replaces the single-cycle combinational-read data memory with an access port that has a request/ready handshake, a configurable fixed access latency, byte and word accesses (LDRB/STRB, LDR/STR) and error reporting for bad addresses. It sits between the core's load/store path and the word array. The core issues one access, stalls until `done`, then issues the next.

## Interface
- `DEPTH`, 64: memory size in 32-bit words. Must be a power of two and ≥2.
- `LATENCY`, 2: cycles from accept edge to completion edge. Legal range 1..16.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in 1: access request. Sampled only at a rising edge where `ready`=1.
- `we` in 1: 1 = store, 0 = load.
- `size` in 1: 0 = word, 1 = byte.
- `addr` in 32: byte address.
- `wd` in 32: store data. Byte stores use `wd[7:0]`.
- `ready` out 1: block can accept a request this cycle.
- `done` out 1: one-cycle completion pulse.
- `rd` out 32: load result. Valid while `done`=1 and held until the next `done`.
- `err` out 1: the completed access faulted. Valid with `done`, held with `rd`.

## Operation
- Storage: `DEPTH`×32 array. Not reset and not initialised. Contents survive `reset`.
- FSM states:
  - IDLE: `ready`=1.
  - WAIT: `ready`=0, down-counter running.
  - DONE: `ready`=1, `done`=1.
- Accept: at a rising edge with `req`=1 and state IDLE or DONE, latch `we`, `size`, `addr`, `wd`. Load the counter with `LATENCY`-1 and enter WAIT.
- WAIT: decrement the counter each edge. At the edge where the counter is 0, perform the access and enter DONE. If `LATENCY`=1, this edge is the one immediately after the accept edge.
- DONE lasts one cycle. Next state:
  - WAIT if a new request is accepted at the DONE-exit edge (back-to-back);
  - otherwise IDLE.
- Fault checks use the latched request:
  - out of range: `addr[31:2]` ≥ `DEPTH`;
  - misaligned: `size`=0 and `addr[1:0]`≠0.
- On a fault: no array write, `rd`=0, `err`=1.
- Word load: `rd` = word[`addr[31:2]`].
- Byte load: `rd` = {24'b0, byte lane `addr[1:0]`}. Lane 0 = bits 7:0, lane 3 = bits 31:24.
- Word store: the whole word is written. `rd` = `wd` (write-through echo).
- Byte store: only lane `addr[1:0]` is written with `wd[7:0]`; the other lanes are unchanged. `rd` = the full updated word.
- Requests while `ready`=0 are ignored and not queued. The requester must re-present after `done`.
- Changes to inputs after acceptance have no effect on the in-flight access.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `ready`=1, `done`=0, `rd`=0, `err`=0, counter 0.
- No request is accepted while `reset`=1.
- Reset mid-WAIT: the in-flight access is aborted and no write occurs. Reset in the same cycle as the completion edge also means no write.
- Latency: the accept edge is E. The array update and `rd`/`err` register update happen at edge E+`LATENCY`. `done`=1 in the cycle after that edge.
- `ready`=0 from edge E until the DONE cycle.
- Minimum request-to-request period: `LATENCY`+1 cycles.
- A load issued in the DONE cycle of a store to the same word returns the stored data, because the write has committed at the completion edge.
- `rd` and `err` are registered and change only at completion edges or on reset.

## Test plan
1. Reset, then word store 0x0000_0007 @ 100. `LATENCY`=2: `done` appears 2 cycles after accept, `err`=0, `rd`=7. A following word load @100 returns 7 with `err`=0.
2. Word store 0x1122_3344 @ 8, then byte store 0xAB @ 9:
   - byte load @9 returns 0x0000_00AB;
   - word load @8 returns 0x1122_AB44.
3. Word load @ 6 (misaligned) and word store @ 4·`DEPTH` (out of range): each gives `done`, `err`=1, `rd`=0. A word load @4·`DEPTH`-4 afterwards shows the previous contents unchanged.
4. Back-to-back: hold `req`=1 with alternating store/load to @12 for 4 accesses. Accepts are exactly `LATENCY`+1 cycles apart, and each load returns the preceding store's data. Pulses of `req` while `ready`=0 produce no extra `done`.
5. Store 0xDEAD_BEEF @ 20, then assert `reset` one cycle after accept (mid-WAIT):
   - all outputs go to reset values immediately and no `done` follows;
   - after release, a load @20 returns the pre-reset contents, not 0xDEAD_BEEF.
6. Repeat scenarios 1 and 4 with `LATENCY`=1 and `LATENCY`=16 to confirm the latency and period formulas at the parameter bounds.
